// File: rtl/encode4to2_sync_pkg.sv
// Shared constants and helpers for the 4:2 request encoder.
package encode4to2_sync_pkg;

  localparam int unsigned CODE_W = 2;
  localparam int unsigned N_REQ  = 4;

  localparam logic [N_REQ-1:0] REQ_IDLE = 4'b1111;

  // Index of the most significant set bit; returns 0 for an all-zero vector.
  function automatic logic [CODE_W-1:0] highest_set(input logic [N_REQ-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_nstage.sv
// Single-bit N-flop synchronizer; resets to 1 so idle active-low lines look inactive.
module sync_nstage #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/encode4to2_sync.sv
// Synchronizes four active-low request lines, captures falling edges as pending
// requests and emits one 2-bit code per request over a valid/ready handshake.
module encode4to2_sync
  import encode4to2_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_n,
  input  logic              en_n,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [N_REQ-1:0]  pending,
  output logic              overrun
);

  logic [N_REQ-1:0]  req_sync;
  logic [N_REQ-1:0]  prev_q, prev_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [CODE_W-1:0] last_q, last_d;

  logic [N_REQ-1:0]   fall;
  logic               load;
  logic [CODE_W-1:0]  rr_start;
  logic [2*N_REQ-1:0] rot_wide;
  logic [N_REQ-1:0]   rr_vec;
  logic [CODE_W-1:0]  rr_idx;
  logic [CODE_W-1:0]  grant_idx;
  logic [N_REQ-1:0]   grant_oh;
  logic [N_REQ-1:0]   drop;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sync
    sync_nstage #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (req_n[gi]),
      .q  (req_sync[gi])
    );
  end

  always_comb begin
    fall = prev_q & ~req_sync & {N_REQ{~en_n}};
    load = (~valid_q | ready) & (|pending_q);

    // Rotate so the search begins at last+1, then bit-reverse so that the
    // highest-set-bit helper finds the first request in upward order.
    rr_start = last_q + 1'b1;
    rot_wide = {pending_q, pending_q} >> rr_start;
    rr_vec   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      rr_vec[N_REQ-1-j] = rot_wide[j];
    end
    rr_idx = rr_start + ~highest_set(rr_vec);

    grant_idx = (ROUND_ROBIN != 0) ? rr_idx : highest_set(pending_q);
    grant_oh  = load ? (N_REQ'(1) << grant_idx) : '0;

    // A fall on the index being retired this edge re-arms it without loss.
    drop      = fall & pending_q & ~grant_oh;
    pending_d = (pending_q & ~grant_oh) | fall;
    overrun_d = |drop;
    prev_d    = req_sync;

    code_d  = code_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load) begin
      code_d  = grant_idx;
      valid_d = 1'b1;
      if (ROUND_ROBIN != 0) last_d = grant_idx;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= REQ_IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      last_q    <= CODE_W'(N_REQ - 1);
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      last_q    <= last_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule
